// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the PC register, issues single-outstanding
// word fetches to instruction memory and buffers results in a 2-entry queue.
module instr_fetch #(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   pc_q,
    output logic               pc_en,
    output logic [WIDTH-1:0]   pc_d,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_target,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [WIDTH-1:0]   id_pc
);

    typedef enum logic [1:0] {ISSUE, WAIT, DRAIN} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [INSTR_W-1:0] q_instr [2];
    logic [WIDTH-1:0]   q_pc [2];
    logic [WIDTH-1:0]   pend_pc;
    logic               grant;
    logic               push;
    logic               pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect only changes where we go when a response is still owed:
    // that response must be drained before the next request.
    always_comb begin
        state_next = state;
        case (state)
            ISSUE: begin
                if (grant) begin
                    state_next = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = ISSUE;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_next = ISSUE;
                end
            end
            default: state_next = ISSUE;
        endcase
    end

    always_comb begin
        imem_req = rst && (state == ISSUE) && (count < 2'd2);
        grant    = imem_req && imem_gnt;
        pc_en    = 1'b0;
        pc_d     = '0;
        if (rst) begin
            if (redirect_valid) begin
                pc_en = 1'b1;
                pc_d  = redirect_target;
            end else if (grant) begin
                pc_en = 1'b1;
                pc_d  = pc_q + WIDTH'(4);
            end
        end
        push = rst && (state == WAIT) && imem_rvalid && !redirect_valid;
        pop  = id_valid && id_ready && !redirect_valid;
    end

    assign imem_addr = {pc_q[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_pc <= '0;
        end else if (grant) begin
            pend_pc <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || redirect_valid) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= pend_pc;
        end
    end

    // Head is masked when empty so stale entries never leak to decode.
    assign id_valid = (count != 2'd0);
    assign id_instr = id_valid ? q_instr[rd_ptr] : '0;
    assign id_pc    = id_valid ? q_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a PC register and memory model surround
// the DUT, and a monitor checks every instruction consumed by decode.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_q = 32'h0;
    logic        pc_en;
    logic [31:0] pc_d;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expQueue[$];
    exp_t        monEntry;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic        pcLoad = 1'b1;
    int          grantBudget = 0;
    int          memLatency = 1;
    int          memCount = 0;
    logic        memBusy = 1'b0;
    logic [31:0] memAddr = 32'h0;

    instr_fetch #(.WIDTH(32), .INSTR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .pc_q(pc_q),
        .pc_en(pc_en),
        .pc_d(pc_d),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instr(id_instr),
        .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pcLoad) begin
            pc_q <= 32'h0;
        end else if (pc_en) begin
            pc_q <= pc_d;
        end
    end

    // Memory returns addr ^ 0xDEADBEEF, memLatency cycles after the grant.
    always @(negedge clk) begin
        if (!rst) begin
            memBusy     = 1'b0;
            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (memBusy) begin
                memCount = memCount - 1;
                if (memCount == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memAddr ^ 32'hDEAD_BEEF;
                    memBusy     = 1'b0;
                end
            end
            imem_gnt = (grantBudget > 0);
            if (imem_req && imem_gnt) begin
                memBusy     = 1'b1;
                memCount    = memLatency;
                memAddr     = imem_addr;
                grantBudget = grantBudget - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (act !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && id_valid && id_ready) begin
            if (expQueue.size() == 0) begin
                testsRun    = testsRun + 1;
                testsFailed = testsFailed + 1;
                $display("[TB] FAIL unexpected_pop: got pc %h expected no entry", id_pc);
            end else begin
                monEntry = expQueue.pop_front();
                checkOutput("pop_pc", id_pc, monEntry.pc);
                checkOutput("pop_instr", id_instr, monEntry.instr);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic expectFetch(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        expQueue.push_back(e);
    endtask

    task automatic applyStimulus(input int budget, input int latency, input logic ready);
        @(posedge clk);
        #1;
        grantBudget = budget;
        memLatency  = latency;
        id_ready    = ready;
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        while ((memBusy || id_valid || expQueue.size() != 0) && n < 60) begin
            cyc();
            n = n + 1;
        end
        if (n >= 60) begin
            testsRun    = testsRun + 1;
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL quiesce: got %0d pending expected 0", expQueue.size());
        end
        cyc();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        cyc();
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_pc_en", {31'b0, pc_en}, 32'h0);
        checkOutput("rst_pc_d", pc_d, 32'h0);
        checkOutput("rst_id_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_instr", id_instr, 32'h0);

        // Streaming from 0 with a 1-cycle memory.
        expectFetch(32'h0, 32'hDEAD_BEEF);
        expectFetch(32'h4, 32'hDEAD_BEEB);
        expectFetch(32'h8, 32'hDEAD_BEE7);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pcLoad = 1'b0;
        grantBudget = 3;
        cyc();
        checkOutput("t1_req", {31'b0, imem_req}, 32'h1);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        checkOutput("t1_pc_en", {31'b0, pc_en}, 32'h1);
        checkOutput("t1_pc_d", pc_d, 32'h4);
        cyc();
        checkOutput("t1_wait_req", {31'b0, imem_req}, 32'h0);
        cyc();
        checkOutput("t1_first_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("t1_first_pc", id_pc, 32'h0);
        checkOutput("t1_addr1", imem_addr, 32'h4);
        cyc();
        checkOutput("t1_gap_valid", {31'b0, id_valid}, 32'h0);
        cyc();
        checkOutput("t1_addr2", imem_addr, 32'h8);
        quiesce();

        // Decode stalled: queue fills to two entries and fetch stops.
        expectFetch(32'hC, 32'hDEAD_BEE3);
        expectFetch(32'h10, 32'hDEAD_BEFF);
        applyStimulus(10, 1, 1'b0);
        repeat (6) cyc();
        checkOutput("t2_full_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t2_head_pc", id_pc, 32'hC);
        checkOutput("t2_head_instr", id_instr, 32'hDEAD_BEE3);
        repeat (4) cyc();
        checkOutput("t2_stable_pc", id_pc, 32'hC);
        checkOutput("t2_still_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t2_pc_q", pc_q, 32'h14);
        applyStimulus(0, 1, 1'b1);
        quiesce();

        // Redirect while waiting; the late response is drained.
        expectFetch(32'h100, 32'hDEAD_BFEF);
        applyStimulus(2, 2, 1'b1);
        cyc();
        checkOutput("t3_addr", imem_addr, 32'h14);
        @(posedge clk);
        #1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        cyc();
        checkOutput("t3_pc_en", {31'b0, pc_en}, 32'h1);
        checkOutput("t3_pc_d", pc_d, 32'h100);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        cyc();
        checkOutput("t3_drain_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t3_drain_valid", {31'b0, id_valid}, 32'h0);
        cyc();
        checkOutput("t3_new_req", {31'b0, imem_req}, 32'h1);
        checkOutput("t3_new_addr", imem_addr, 32'h100);
        quiesce();

        // Redirect in the same cycle as a grant.
        expectFetch(32'h200, 32'hDEAD_BCEF);
        applyStimulus(2, 1, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        cyc();
        checkOutput("t4_req", {31'b0, imem_req}, 32'h1);
        checkOutput("t4_pc_d", pc_d, 32'h200);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        cyc();
        checkOutput("t4_drain_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t4_drain_valid", {31'b0, id_valid}, 32'h0);
        cyc();
        checkOutput("t4_new_addr", imem_addr, 32'h200);
        quiesce();

        // Grant withheld, then a 3-cycle memory.
        expectFetch(32'h204, 32'hDEAD_BCEB);
        applyStimulus(0, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checkOutput("t5_req_held", {31'b0, imem_req}, 32'h1);
            checkOutput("t5_no_pc_en", {31'b0, pc_en}, 32'h0);
            checkOutput("t5_pc_same", pc_q, 32'h204);
        end
        applyStimulus(1, 3, 1'b1);
        cyc();
        checkOutput("t5_grant_pc_d", pc_d, 32'h208);
        repeat (3) cyc();
        checkOutput("t5_not_yet", {31'b0, id_valid}, 32'h0);
        cyc();
        checkOutput("t5_valid", {31'b0, id_valid}, 32'h1);
        checkOutput("t5_pc", id_pc, 32'h204);
        quiesce();

        // Reset while a fetch is outstanding and one entry is queued.
        applyStimulus(2, 3, 1'b0);
        repeat (5) cyc();
        checkOutput("t6_queued", {31'b0, id_valid}, 32'h1);
        checkOutput("t6_queued_pc", id_pc, 32'h208);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        checkOutput("t6_rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t6_rst_pc_en", {31'b0, pc_en}, 32'h0);
        expectFetch(32'h210, 32'hDEAD_BCFF);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        id_ready    = 1'b1;
        grantBudget = 1;
        cyc();
        checkOutput("t6_flushed", {31'b0, id_valid}, 32'h0);
        checkOutput("t6_resume_req", {31'b0, imem_req}, 32'h1);
        checkOutput("t6_resume_addr", imem_addr, 32'h210);
        quiesce();

        checkOutput("sb_empty", expQueue.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
